// File: rtl/robot_motion_seq_if.sv
// Motion command stream: valid/ready handshake carrying an opcode and a target speed.
interface robot_motion_seq_if #(
    parameter int unsigned DUTY_W = 8
) ();
    logic              cmd_valid;
    logic              cmd_ready;
    logic [2:0]        cmd_op;
    logic [DUTY_W-1:0] cmd_speed;

    modport master (output cmd_valid, output cmd_op, output cmd_speed, input cmd_ready);
    modport slave  (input cmd_valid, input cmd_op, input cmd_speed, output cmd_ready);
endinterface

// File: rtl/robot_motion_seq.sv
// Robot motion sequencer: ramped FWD/BWD with reverse-through-zero drain, timed turns,
// obstacle back-off and sticky error, driving one-hot motor lines and a PWM pulse.
module robot_motion_seq #(
    parameter int unsigned DUTY_W       = 8,
    parameter int unsigned RAMP_STEP    = 16,
    parameter int unsigned RAMP_DIV     = 4,
    parameter int unsigned TURN_CYC     = 64,
    parameter int unsigned BACKOFF_CYC  = 32,
    parameter int unsigned BACKOFF_DUTY = 64,
    parameter int unsigned CNT_W        = 16
) (
    input  logic              clk_i,
    input  logic              rst_i,
    robot_motion_seq_if.slave cmd_io,
    input  logic              obstacle_i,
    input  logic              error_i,
    input  logic              recover_i,
    output logic [2:0]        state_o,
    output logic              motor_fwd_o,
    output logic              motor_bwd_o,
    output logic              motor_left_o,
    output logic              motor_right_o,
    output logic              motor_stop_o,
    output logic [DUTY_W-1:0] duty_o,
    output logic              pwm_o,
    output logic              busy_o
);

    localparam int unsigned PW = (RAMP_DIV > 1) ? $clog2(RAMP_DIV) : 1;
    localparam logic [DUTY_W:0]   StepW    = (DUTY_W + 1)'(RAMP_STEP);
    localparam logic [DUTY_W-1:0] BoDuty   = DUTY_W'(BACKOFF_DUTY);
    localparam logic [CNT_W-1:0]  TurnCnt  = CNT_W'(TURN_CYC);
    localparam logic [CNT_W-1:0]  BoCnt    = CNT_W'(BACKOFF_CYC);
    localparam logic [PW-1:0]     PrescTop = PW'(RAMP_DIV - 1);

    localparam logic [2:0] OpFwd   = 3'd1;
    localparam logic [2:0] OpBwd   = 3'd2;
    localparam logic [2:0] OpLeft  = 3'd3;
    localparam logic [2:0] OpRight = 3'd4;

    typedef enum logic [2:0] {
        StIdle    = 3'd0,
        StFwd     = 3'd1,
        StBwd     = 3'd2,
        StLeft    = 3'd3,
        StRight   = 3'd4,
        StBackoff = 3'd5,
        StError   = 3'd6
    } state_e;

    state_e            state_q, state_d;
    logic [DUTY_W-1:0] duty_q, duty_d;
    logic [DUTY_W-1:0] target_q, target_d;
    logic              pend_q, pend_d;
    logic [2:0]        pend_op_q, pend_op_d;
    logic [DUTY_W-1:0] pend_speed_q, pend_speed_d;
    logic [CNT_W-1:0]  timer_q, timer_d;
    logic [PW-1:0]     presc_q, presc_d;
    logic [DUTY_W-1:0] pwm_cnt_q;
    logic              pwm_q, pwm_d;
    logic              ready_q, ready_d;
    logic              busy_q, busy_d;
    logic [4:0]        motor_q, motor_d;  // {fwd, bwd, left, right, stop}

    logic              tick;
    logic              accept;
    logic              do_exec;
    logic [2:0]        exec_op;
    logic [DUTY_W-1:0] exec_speed;
    logic [DUTY_W:0]   up_sum;
    logic [DUTY_W:0]   dn_lim;
    logic [DUTY_W-1:0] ramp_val;

    assign tick    = (presc_q == PrescTop);
    assign presc_d = tick ? '0 : presc_q + PW'(1);
    assign accept  = cmd_io.cmd_valid & ready_q;

    // Ramp arithmetic carries one extra bit so a large step cannot wrap past the target.
    always_comb begin
        up_sum = {1'b0, duty_q} + StepW;
        dn_lim = {1'b0, target_q} + StepW;
        if (duty_q < target_q) begin
            ramp_val = (up_sum > {1'b0, target_q}) ? target_q : up_sum[DUTY_W-1:0];
        end else if ({1'b0, duty_q} >= dn_lim) begin
            ramp_val = duty_q - StepW[DUTY_W-1:0];
        end else begin
            ramp_val = target_q;
        end
    end

    always_comb begin
        state_d      = state_q;
        duty_d       = duty_q;
        target_d     = target_q;
        pend_d       = pend_q;
        pend_op_d    = pend_op_q;
        pend_speed_d = pend_speed_q;
        timer_d      = timer_q;
        do_exec      = 1'b0;
        exec_op      = cmd_io.cmd_op;
        exec_speed   = cmd_io.cmd_speed;

        if (error_i) begin
            state_d  = StError;
            duty_d   = '0;
            target_d = '0;
            pend_d   = 1'b0;
            timer_d  = '0;
        end else begin
            unique case (state_q)
                StIdle: begin
                    if (accept) do_exec = 1'b1;
                end
                StFwd, StBwd: begin
                    if (tick) duty_d = ramp_val;
                    if (state_q == StFwd && obstacle_i) begin
                        state_d  = StBackoff;
                        duty_d   = BoDuty;
                        target_d = '0;
                        timer_d  = BoCnt;
                        pend_d   = 1'b0;
                    end else if (accept) begin
                        if ((state_q == StFwd && cmd_io.cmd_op == OpFwd) ||
                            (state_q == StBwd && cmd_io.cmd_op == OpBwd)) begin
                            target_d = cmd_io.cmd_speed;
                        end else begin
                            target_d     = '0;
                            pend_d       = 1'b1;
                            pend_op_d    = cmd_io.cmd_op;
                            pend_speed_d = cmd_io.cmd_speed;
                        end
                    end else if (pend_q && duty_q == '0) begin
                        do_exec    = 1'b1;
                        exec_op    = pend_op_q;
                        exec_speed = pend_speed_q;
                    end
                end
                StLeft, StRight, StBackoff: begin
                    timer_d = timer_q - CNT_W'(1);
                    if (timer_q == CNT_W'(1)) begin
                        state_d = StIdle;
                        duty_d  = '0;
                        timer_d = '0;
                    end
                end
                StError: begin
                    if (recover_i) state_d = StIdle;
                end
                default: state_d = StIdle;
            endcase
        end

        // Dispatch a command as seen from IDLE, whether fresh or released by a drain.
        if (do_exec) begin
            state_d  = StIdle;
            duty_d   = '0;
            target_d = '0;
            timer_d  = '0;
            pend_d   = 1'b0;
            case (exec_op)
                OpFwd: begin
                    if (!obstacle_i) begin
                        state_d  = StFwd;
                        target_d = exec_speed;
                    end
                end
                OpBwd: begin
                    state_d  = StBwd;
                    target_d = exec_speed;
                end
                OpLeft, OpRight: begin
                    state_d = (exec_op == OpLeft) ? StLeft : StRight;
                    duty_d  = exec_speed;
                    timer_d = TurnCnt;
                end
                default: ;
            endcase
        end
    end

    always_comb begin
        motor_d = 5'b00001;
        unique case (state_d)
            StFwd:              motor_d = 5'b10000;
            StBwd, StBackoff:   motor_d = 5'b01000;
            StLeft:             motor_d = 5'b00100;
            StRight:            motor_d = 5'b00010;
            StIdle, StError:    motor_d = 5'b00001;
            default:            motor_d = 5'b00001;
        endcase
        ready_d = (state_d == StIdle) || ((state_d == StFwd || state_d == StBwd) && !pend_d);
        busy_d  = (state_d != StIdle) || pend_d;
        pwm_d   = (pwm_cnt_q < duty_q) && !motor_q[0];
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state_q      <= StIdle;
            duty_q       <= '0;
            target_q     <= '0;
            pend_q       <= 1'b0;
            pend_op_q    <= '0;
            pend_speed_q <= '0;
            timer_q      <= '0;
            presc_q      <= '0;
            pwm_cnt_q    <= '0;
            pwm_q        <= 1'b0;
            ready_q      <= 1'b0;
            busy_q       <= 1'b0;
            motor_q      <= 5'b00001;
        end else begin
            state_q      <= state_d;
            duty_q       <= duty_d;
            target_q     <= target_d;
            pend_q       <= pend_d;
            pend_op_q    <= pend_op_d;
            pend_speed_q <= pend_speed_d;
            timer_q      <= timer_d;
            presc_q      <= presc_d;
            pwm_cnt_q    <= pwm_cnt_q + DUTY_W'(1);
            pwm_q        <= pwm_d;
            ready_q      <= ready_d;
            busy_q       <= busy_d;
            motor_q      <= motor_d;
        end
    end

    assign cmd_io.cmd_ready = ready_q;
    assign state_o          = state_q;
    assign duty_o           = duty_q;
    assign pwm_o            = pwm_q;
    assign busy_o           = busy_q;
    assign motor_fwd_o      = motor_q[4];
    assign motor_bwd_o      = motor_q[3];
    assign motor_left_o     = motor_q[2];
    assign motor_right_o    = motor_q[1];
    assign motor_stop_o     = motor_q[0];

endmodule

// File: tb/tb_robot_motion_seq.sv
// Directed bench for robot_motion_seq: default-parameter DUT plus a RAMP_STEP=255 instance.
module tb_robot_motion_seq;

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    int vec_cnt = 0;
    int err_cnt = 0;

    robot_motion_seq_if #(.DUTY_W(8)) a_if ();
    robot_motion_seq_if #(.DUTY_W(8)) b_if ();

    logic       a_obst = 1'b0, a_err = 1'b0, a_rec = 1'b0;
    logic [2:0] a_state;
    logic       a_fwd, a_bwd, a_left, a_right, a_stop, a_pwm, a_busy;
    logic [7:0] a_duty;

    logic [2:0] b_state;
    logic       b_fwd, b_bwd, b_left, b_right, b_stop, b_pwm, b_busy;
    logic [7:0] b_duty;

    robot_motion_seq dut_a (
        .clk_i         (clk),
        .rst_i         (rst),
        .cmd_io        (a_if.slave),
        .obstacle_i    (a_obst),
        .error_i       (a_err),
        .recover_i     (a_rec),
        .state_o       (a_state),
        .motor_fwd_o   (a_fwd),
        .motor_bwd_o   (a_bwd),
        .motor_left_o  (a_left),
        .motor_right_o (a_right),
        .motor_stop_o  (a_stop),
        .duty_o        (a_duty),
        .pwm_o         (a_pwm),
        .busy_o        (a_busy)
    );

    robot_motion_seq #(.RAMP_STEP(255)) dut_b (
        .clk_i         (clk),
        .rst_i         (rst),
        .cmd_io        (b_if.slave),
        .obstacle_i    (1'b0),
        .error_i       (1'b0),
        .recover_i     (1'b0),
        .state_o       (b_state),
        .motor_fwd_o   (b_fwd),
        .motor_bwd_o   (b_bwd),
        .motor_left_o  (b_left),
        .motor_right_o (b_right),
        .motor_stop_o  (b_stop),
        .duty_o        (b_duty),
        .pwm_o         (b_pwm),
        .busy_o        (b_busy)
    );

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic send_a(input logic [2:0] op, input logic [7:0] spd);
        int n = 0;
        a_if.cmd_valid = 1'b1;
        a_if.cmd_op    = op;
        a_if.cmd_speed = spd;
        while (!a_if.cmd_ready && n < 200) begin
            step();
            n++;
        end
        step();
        a_if.cmd_valid = 1'b0;
    endtask

    task automatic send_b(input logic [2:0] op, input logic [7:0] spd);
        int n = 0;
        b_if.cmd_valid = 1'b1;
        b_if.cmd_op    = op;
        b_if.cmd_speed = spd;
        while (!b_if.cmd_ready && n < 200) begin
            step();
            n++;
        end
        step();
        b_if.cmd_valid = 1'b0;
    endtask

    // Advances until the selected DUT's duty changes; cycles=64 means it never did.
    task automatic wait_duty(input int sel, output int cycles);
        logic [7:0] prev;
        prev   = sel ? b_duty : a_duty;
        cycles = 0;
        do begin
            step();
            cycles++;
        end while (((sel ? b_duty : a_duty) == prev) && cycles < 64);
    endtask

    task automatic wait_idle_a(output int cycles);
        cycles = 0;
        while (a_state != 3'd0 && cycles < 300) begin
            step();
            cycles++;
        end
    endtask

    task automatic test_reset();
        rst = 1'b1;
        repeat (3) step();
        rst = 1'b0;
        vec_cnt++; if (a_state !== 3'd0) begin err_cnt++;
            $display("FAIL reset_state: got %0d expected 0", a_state); end
        vec_cnt++; if (a_duty !== 8'd0) begin err_cnt++;
            $display("FAIL reset_duty: got %0d expected 0", a_duty); end
        vec_cnt++; if ({a_fwd, a_bwd, a_left, a_right, a_stop, a_pwm, a_busy} !== 7'b0000100)
            begin err_cnt++; $display("FAIL reset_motor_pwm_busy: got %b expected 0000100",
            {a_fwd, a_bwd, a_left, a_right, a_stop, a_pwm, a_busy}); end
        vec_cnt++; if (a_if.cmd_ready !== 1'b0) begin err_cnt++;
            $display("FAIL reset_ready_low: got %b expected 0", a_if.cmd_ready); end
        step();
        vec_cnt++; if (a_if.cmd_ready !== 1'b1) begin err_cnt++;
            $display("FAIL ready_after_reset: got %b expected 1", a_if.cmd_ready); end
    endtask

    task automatic test_fwd_ramp();
        logic [7:0] exp_seq [7] = '{8'd16, 8'd32, 8'd48, 8'd64, 8'd80, 8'd96, 8'd100};
        int cyc;
        int hi = 0;
        send_a(3'd1, 8'd100);
        vec_cnt++; if (a_state !== 3'd1 || a_fwd !== 1'b1) begin err_cnt++;
            $display("FAIL fwd_enter: got state %0d fwd %b expected 1 1", a_state, a_fwd); end
        for (int i = 0; i < 7; i++) begin
            wait_duty(0, cyc);
            vec_cnt++; if (a_duty !== exp_seq[i]) begin err_cnt++;
                $display("FAIL fwd_ramp_%0d: got %0d expected %0d", i, a_duty, exp_seq[i]); end
            if (i > 0) begin
                vec_cnt++; if (cyc !== 4) begin err_cnt++;
                    $display("FAIL fwd_tick_gap_%0d: got %0d expected 4", i, cyc); end
            end
        end
        repeat (12) step();
        vec_cnt++; if (a_duty !== 8'd100) begin err_cnt++;
            $display("FAIL fwd_hold: got %0d expected 100", a_duty); end
        for (int i = 0; i < 256; i++) begin
            step();
            if (a_pwm) hi++;
        end
        vec_cnt++; if (hi !== 100) begin err_cnt++;
            $display("FAIL pwm_100_of_256: got %0d expected 100", hi); end
    endtask

    task automatic test_reverse_drain();
        logic [7:0] dn_seq [7] = '{8'd84, 8'd68, 8'd52, 8'd36, 8'd20, 8'd4, 8'd0};
        logic [7:0] up_seq [4] = '{8'd16, 8'd32, 8'd48, 8'd50};
        int cyc;
        send_a(3'd2, 8'd50);
        vec_cnt++; if (a_if.cmd_ready !== 1'b0 || a_state !== 3'd1 || a_busy !== 1'b1) begin
            err_cnt++; $display("FAIL drain_start: got ready %b state %0d busy %b expected 0 1 1",
            a_if.cmd_ready, a_state, a_busy); end
        for (int i = 0; i < 7; i++) begin
            wait_duty(0, cyc);
            vec_cnt++; if (a_duty !== dn_seq[i]) begin err_cnt++;
                $display("FAIL drain_%0d: got %0d expected %0d", i, a_duty, dn_seq[i]); end
        end
        vec_cnt++; if (a_state !== 3'd1) begin err_cnt++;
            $display("FAIL drain_zero_state: got %0d expected 1", a_state); end
        step();
        vec_cnt++; if (a_state !== 3'd2 || a_bwd !== 1'b1 || a_if.cmd_ready !== 1'b1) begin
            err_cnt++; $display("FAIL bwd_enter: got state %0d bwd %b ready %b expected 2 1 1",
            a_state, a_bwd, a_if.cmd_ready); end
        for (int i = 0; i < 4; i++) begin
            wait_duty(0, cyc);
            vec_cnt++; if (a_duty !== up_seq[i]) begin err_cnt++;
                $display("FAIL bwd_ramp_%0d: got %0d expected %0d", i, a_duty, up_seq[i]); end
        end
        send_a(3'd0, 8'd0);
        wait_idle_a(cyc);
        vec_cnt++; if (a_state !== 3'd0 || a_duty !== 8'd0 || a_stop !== 1'b1 || a_busy !== 1'b0)
            begin err_cnt++; $display("FAIL stop_to_idle: got state %0d duty %0d stop %b busy %b",
            a_state, a_duty, a_stop, a_busy); end
    endtask

    task automatic test_turn();
        int n = 0;
        int rdy_seen = 0;
        send_a(3'd3, 8'd80);
        vec_cnt++; if (a_state !== 3'd3 || a_duty !== 8'd80 || a_left !== 1'b1) begin
            err_cnt++; $display("FAIL left_enter: got state %0d duty %0d left %b expected 3 80 1",
            a_state, a_duty, a_left); end
        a_if.cmd_valid = 1'b1;
        a_if.cmd_op    = 3'd1;
        a_if.cmd_speed = 8'd10;
        while (a_state == 3'd3 && n < 200) begin
            if (a_if.cmd_ready) rdy_seen++;
            step();
            n++;
        end
        a_if.cmd_valid = 1'b0;
        vec_cnt++; if (n !== 64) begin err_cnt++;
            $display("FAIL left_duration: got %0d expected 64", n); end
        vec_cnt++; if (rdy_seen !== 0) begin err_cnt++;
            $display("FAIL left_ready_low: got %0d ready cycles expected 0", rdy_seen); end
        vec_cnt++; if (a_state !== 3'd0 || a_duty !== 8'd0) begin err_cnt++;
            $display("FAIL left_exit: got state %0d duty %0d expected 0 0", a_state, a_duty); end
        step();
        vec_cnt++; if (a_state !== 3'd0) begin err_cnt++;
            $display("FAIL left_no_late_accept: got %0d expected 0", a_state); end
    endtask

    task automatic test_obstacle();
        int cyc;
        int n = 0;
        send_a(3'd1, 8'd200);
        wait_duty(0, cyc);
        wait_duty(0, cyc);
        a_obst = 1'b1;
        step();
        a_obst = 1'b0;
        vec_cnt++; if (a_state !== 3'd5 || a_duty !== 8'd64 || a_bwd !== 1'b1) begin
            err_cnt++; $display("FAIL backoff_enter: got state %0d duty %0d bwd %b expected 5 64 1",
            a_state, a_duty, a_bwd); end
        while (a_state == 3'd5 && n < 200) begin
            step();
            n++;
        end
        vec_cnt++; if (n !== 32) begin err_cnt++;
            $display("FAIL backoff_duration: got %0d expected 32", n); end
        vec_cnt++; if (a_state !== 3'd0 || a_duty !== 8'd0) begin err_cnt++;
            $display("FAIL backoff_exit: got state %0d duty %0d expected 0 0", a_state, a_duty); end
        a_obst = 1'b1;
        send_a(3'd1, 8'd100);
        repeat (5) step();
        a_obst = 1'b0;
        vec_cnt++; if (a_state !== 3'd0 || a_busy !== 1'b0) begin err_cnt++;
            $display("FAIL idle_fwd_drop: got state %0d busy %b expected 0 0", a_state, a_busy); end
    endtask

    task automatic test_error();
        int cyc;
        send_a(3'd2, 8'd120);
        wait_duty(0, cyc);
        a_err = 1'b1;
        step();
        a_err = 1'b0;
        vec_cnt++; if (a_state !== 3'd6 || a_duty !== 8'd0 || a_stop !== 1'b1) begin
            err_cnt++; $display("FAIL error_enter: got state %0d duty %0d stop %b expected 6 0 1",
            a_state, a_duty, a_stop); end
        a_rec = 1'b1;
        a_err = 1'b1;
        step();
        vec_cnt++; if (a_state !== 3'd6) begin err_cnt++;
            $display("FAIL recover_blocked: got %0d expected 6", a_state); end
        a_err = 1'b0;
        step();
        a_rec = 1'b0;
        vec_cnt++; if (a_state !== 3'd0 || a_if.cmd_ready !== 1'b1) begin err_cnt++;
            $display("FAIL recover_idle: got state %0d ready %b expected 0 1",
            a_state, a_if.cmd_ready); end
        a_if.cmd_valid = 1'b1;
        a_if.cmd_op    = 3'd1;
        a_if.cmd_speed = 8'd50;
        a_err = 1'b1;
        step();
        a_if.cmd_valid = 1'b0;
        a_err = 1'b0;
        a_rec = 1'b1;
        step();
        a_rec = 1'b0;
        repeat (10) step();
        vec_cnt++; if (a_state !== 3'd0 || a_duty !== 8'd0) begin err_cnt++;
            $display("FAIL error_accept_discard: got state %0d duty %0d expected 0 0",
            a_state, a_duty); end
    endtask

    task automatic test_rst_in_drain();
        int cyc;
        send_a(3'd1, 8'd100);
        wait_duty(0, cyc);
        wait_duty(0, cyc);
        send_a(3'd3, 8'd80);
        vec_cnt++; if (a_state !== 3'd1 || a_if.cmd_ready !== 1'b0) begin err_cnt++;
            $display("FAIL pend_held: got state %0d ready %b expected 1 0",
            a_state, a_if.cmd_ready); end
        step();
        rst = 1'b1;
        step();
        vec_cnt++; if (a_state !== 3'd0 || a_duty !== 8'd0 || a_busy !== 1'b0 ||
            a_stop !== 1'b1 || a_if.cmd_ready !== 1'b0) begin err_cnt++;
            $display("FAIL rst_mid_drain: got state %0d duty %0d busy %b stop %b ready %b",
            a_state, a_duty, a_busy, a_stop, a_if.cmd_ready); end
        rst = 1'b0;
        repeat (40) step();
        vec_cnt++; if (a_state !== 3'd0 || a_busy !== 1'b0) begin err_cnt++;
            $display("FAIL pend_lost: got state %0d busy %b expected 0 0", a_state, a_busy); end
    endtask

    task automatic test_big_step();
        int cyc;
        send_b(3'd1, 8'd200);
        wait_duty(1, cyc);
        vec_cnt++; if (b_duty !== 8'd200) begin err_cnt++;
            $display("FAIL big_step_clamp_up: got %0d expected 200", b_duty); end
        send_b(3'd1, 8'd255);
        wait_duty(1, cyc);
        vec_cnt++; if (b_duty !== 8'd255) begin err_cnt++;
            $display("FAIL big_step_no_wrap: got %0d expected 255", b_duty); end
        repeat (9) step();
        vec_cnt++; if (b_duty !== 8'd255) begin err_cnt++;
            $display("FAIL big_step_hold: got %0d expected 255", b_duty); end
        send_b(3'd0, 8'd0);
        wait_duty(1, cyc);
        vec_cnt++; if (b_duty !== 8'd0) begin err_cnt++;
            $display("FAIL big_step_no_underflow: got %0d expected 0", b_duty); end
        repeat (3) step();
        vec_cnt++; if (b_state !== 3'd0 || b_stop !== 1'b1) begin err_cnt++;
            $display("FAIL big_step_idle: got state %0d stop %b expected 0 1", b_state, b_stop); end
    endtask

    initial begin
        a_if.cmd_valid = 1'b0;
        a_if.cmd_op    = 3'd0;
        a_if.cmd_speed = 8'd0;
        b_if.cmd_valid = 1'b0;
        b_if.cmd_op    = 3'd0;
        b_if.cmd_speed = 8'd0;
        test_reset();
        test_fwd_ramp();
        test_reverse_drain();
        test_turn();
        test_obstacle();
        test_error();
        test_rst_in_drain();
        test_big_step();
        $display("== %0d vectors applied, %0d miscompares ==", vec_cnt, err_cnt);
        $finish;
    end

endmodule

// File: doc/robot_motion_seq.md
# robot_motion_seq

Parametrised successor to the robot motion FSM. Accepts a valid/ready motion command stream with a speed field and drives one-hot motor direction outputs plus a PWM duty/pulse. Adds ramped acceleration/deceleration, reverse-through-zero sequencing, timed turns, and an automatic obstacle back-off. Sits between the command decoder and the motor driver pads.

## Interface
- DUTY_W, 8: width of speed, duty and PWM counter.
- RAMP_STEP, 16: duty change per ramp tick; 1..2^DUTY_W-1.
- RAMP_DIV, 4: clocks per ramp tick; ≥1.
- TURN_CYC, 64: clocks a LEFT/RIGHT turn lasts; ≥1.
- BACKOFF_CYC, 32: clocks of reverse motion after an obstacle; ≥1.
- BACKOFF_DUTY, 64: fixed duty during back-off.
- CNT_W, 16: width of turn/back-off timer; must hold max(TURN_CYC, BACKOFF_CYC).
- clk  in  1  sole clock, rising edge.
- rst  in  1  synchronous, active-high reset.
- cmd_valid  in  1  command present.
- cmd_ready  out  1  command can be accepted this cycle.
- cmd_op  in  3  0 STOP, 1 FWD, 2 BWD, 3 LEFT, 4 RIGHT; 5-7 treated as STOP.
- cmd_speed  in  DUTY_W  target duty for the command.
- obstacle  in  1  level, synchronous.
- error  in  1  level, synchronous.
- recover  in  1  level, synchronous.
- state  out  3  IDLE=0, FWD=1, BWD=2, LEFT=3, RIGHT=4, BACKOFF=5, ERROR=6.
- motor_fwd / motor_bwd / motor_left / motor_right / motor_stop  out  1 each  one-hot direction.
- duty  out  DUTY_W  current duty.
- pwm  out  1  pulse output.
- busy  out  1  high when state≠IDLE or a pending op is held.

## Operation
- Accept = cmd_valid & cmd_ready. cmd_ready=1 in IDLE, and in FWD/BWD with no pending op; 0 otherwise and while rst is high.
- Per-cycle priority: error > obstacle > accepted command > timer/ramp completion.
- IDLE: FWD/BWD → that state, target=cmd_speed, duty ramps from 0. LEFT/RIGHT → that state, duty loads cmd_speed directly, timer=TURN_CYC. STOP → stay. FWD with obstacle=1 is accepted and dropped (stay IDLE).
- FWD/BWD, same-direction op: target updates, ramp continues toward it. Any other op starts a drain: target=0, op and speed latched as pending, cmd_ready=0, state unchanged. When duty reaches 0, the pending op executes as from IDLE (STOP → IDLE) in the same transition.
- LEFT/RIGHT: timer decrements every cycle. After TURN_CYC cycles in the state → IDLE, duty=0.
- obstacle=1 in FWD (including drain) → BACKOFF: pending cleared, duty=BACKOFF_DUTY, timer=BACKOFF_CYC. After BACKOFF_CYC cycles → IDLE, duty=0. obstacle is ignored in all other states apart from the IDLE FWD drop.
- error=1 in any state → ERROR: duty=0, target=0, pending and timer cleared. ERROR → IDLE only on recover=1 with error=0. recover is ignored elsewhere.
- Ramp: a free-running prescaler asserts tick every RAMP_DIV clocks from reset release. On tick, if duty<target: duty=min(duty+RAMP_STEP, target), computed in DUTY_W+1 bits. If duty>target: duty=max(duty−RAMP_STEP, target), with no underflow. Ramping applies in FWD/BWD only.
- Motor decode: fwd←FWD; bwd←BWD|BACKOFF; left←LEFT; right←RIGHT; stop←IDLE|ERROR. Exactly one is high.
- PWM: pwm_cnt is a free-running DUTY_W counter that wraps. pwm=(pwm_cnt<duty)&~motor_stop. duty=0 gives constant low; duty=2^W−1 gives low 1 of every 2^W cycles.

## Timing
- All outputs are registered. state, duty and motor_* change on the clock edge after the accept or event cycle.
- Reset values: state=0, duty=0, pwm=0, motor_stop=1, other motor_*=0, busy=0, cmd_ready=0. cmd_ready rises the cycle after rst falls.
- rst mid-operation aborts the sequence: timers, pending, prescaler and pwm_cnt all clear.
- Error in the same cycle as an accept: the command is consumed and discarded.
- Obstacle in the same cycle as an accept in FWD: the command is discarded and BACKOFF is entered.
- Drain-complete and turn/back-off expiry take effect the cycle after duty==0 or timer==1.

## Test plan
- rst high 3 cycles, then FWD with speed 100 (defaults) → state=1 the next cycle; duty 16,32,…,96,100 on successive ticks; 100 held; pwm high 100 of every 256 cycles.
- At duty 100 in FWD, issue BWD speed 50 → cmd_ready=0 and state stays 1 while duty falls to 0; then state=2, motor_bwd=1, duty ramps to 50.
- LEFT speed 80 from IDLE → state=3, duty=80 next cycle; after exactly 64 cycles state=0, duty=0; commands offered meanwhile are not accepted.
- FWD at speed 200, assert obstacle for 1 cycle → state=5, duty=64, motor_bwd=1 for 32 cycles, then IDLE. FWD with obstacle held in IDLE → stays IDLE.
- error pulse during BWD → state=6, duty=0, motor_stop=1. recover while error=1 → no change. recover with error=0 → IDLE.
- rst during a drain → all reset values next cycle, pending lost. Boundary checks: RAMP_STEP=255 with target 255 gives no overshoot; target 0 gives no underflow.
